// File: rtl/sram_ctl_pkg.sv
// Shared definitions for the SRAM controller read and write paths:
// default geometry, arbitration mode encodings and a width helper.
package sram_ctl_pkg;

    localparam int PORTS    = 16;
    localparam int DATA_W   = 256;
    localparam int ADDR_W   = 14;
    localparam int WEIGHT_W = 4;
    localparam int SRAM_LAT = 2;

    localparam logic MODE_SP  = 1'b0;
    localparam logic MODE_WRR = 1'b1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/wrr_pick.sv
// Circular first-one finder: returns the first set request at or after
// start, wrapping modulo num_of_ports, plus a found flag.
module wrr_pick #(
    parameter int num_of_ports = 16,
    parameter int ptr_width    = 4
) (
    input  logic [num_of_ports-1:0] req,
    input  logic [ptr_width-1:0]    start,
    output logic [ptr_width-1:0]    idx,
    output logic                    found
);

    logic [num_of_ports-1:0] rot;
    logic [ptr_width:0]      off;
    logic [ptr_width:0]      sum;

    always_comb begin
        // Rotate so that bit 0 corresponds to the start index.
        rot   = num_of_ports'({req, req} >> start);
        found = 1'b0;
        off   = '0;
        for (int k = num_of_ports - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                off   = (ptr_width + 1)'(k);
            end
        end
        sum = {1'b0, start} + off;
        if (sum >= (ptr_width + 1)'(num_of_ports)) begin
            sum = sum - (ptr_width + 1)'(num_of_ports);
        end
        idx = sum[ptr_width-1:0];
    end

endmodule

// File: rtl/read_arbiter.sv
// SRAM read arbiter: strict-priority or weighted round-robin selection,
// one read issued per cycle, data routed back through a port-tag pipeline.
module read_arbiter
    import sram_ctl_pkg::*;
#(
    parameter int num_of_ports       = PORTS,
    parameter int arbiter_data_width = DATA_W,
    parameter int addr_width         = ADDR_W,
    parameter int sram_latency       = SRAM_LAT,
    parameter int weight_width       = WEIGHT_W
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 sp0_wrr1,
    input  logic [num_of_ports-1:0]              rd_req_p,
    input  logic [num_of_ports*addr_width-1:0]   rd_addr_p,
    input  logic [num_of_ports*weight_width-1:0] wrr_weight_p,
    output logic [num_of_ports-1:0]              rd_gnt,
    output logic                                 sram_rd_en,
    output logic [addr_width-1:0]                sram_rd_addr,
    input  logic [arbiter_data_width-1:0]        sram_rd_data,
    output logic [arbiter_data_width-1:0]        data_out,
    output logic [num_of_ports-1:0]              data_out_valid
);

    localparam int PTR_W = (clog2(num_of_ports) < 1) ? 1 : clog2(num_of_ports);
    localparam int LAST  = sram_latency - 1;

    logic [PTR_W-1:0]        ptr_reg, ptr_next;
    logic [weight_width-1:0] cnt_reg, cnt_next;
    logic                    mode_prev_reg;

    logic [weight_width-1:0] w_eff    [num_of_ports];
    logic [addr_width-1:0]   addr_arr [num_of_ports];

    logic [PTR_W-1:0]        ptr_wrap, pick_start, pick_idx, gnt_idx;
    logic                    pick_found, stay, gnt_valid, mode_change;
    logic [weight_width-1:0] cnt_eff;

    logic                          sram_rd_en_reg;
    logic [addr_width-1:0]         sram_rd_addr_reg;
    logic [PTR_W-1:0]              issue_port_reg;
    logic                          tag_valid_reg [sram_latency];
    logic [PTR_W-1:0]              tag_port_reg  [sram_latency];
    logic [arbiter_data_width-1:0] data_out_reg;
    logic [num_of_ports-1:0]       data_out_valid_reg;

    genvar gi;
    generate
        for (gi = 0; gi < num_of_ports; gi++) begin : g_port
            logic [weight_width-1:0] w_raw;
            assign w_raw         = wrr_weight_p[gi*weight_width +: weight_width];
            assign w_eff[gi]     = (w_raw == '0) ? weight_width'(1) : w_raw;
            assign addr_arr[gi]  = rd_addr_p[gi*addr_width +: addr_width];
        end
    endgenerate

    // WRR scans from ptr+1 so ptr itself is considered last; SP scans from 0.
    assign ptr_wrap   = (ptr_reg == PTR_W'(num_of_ports - 1)) ? '0 : ptr_reg + 1'b1;
    assign pick_start = (sp0_wrr1 == MODE_WRR) ? ptr_wrap : '0;

    wrr_pick #(
        .num_of_ports (num_of_ports),
        .ptr_width    (PTR_W)
    ) u_pick (
        .req   (rd_req_p),
        .start (pick_start),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_comb begin
        mode_change = (sp0_wrr1 != mode_prev_reg);
        cnt_eff     = mode_change ? '0 : cnt_reg;
        stay        = (sp0_wrr1 == MODE_WRR) && rd_req_p[ptr_reg] && (cnt_eff < w_eff[ptr_reg]);
        gnt_valid   = stay || pick_found;
        gnt_idx     = stay ? ptr_reg : pick_idx;
        ptr_next    = ptr_reg;
        cnt_next    = cnt_eff;
        if ((sp0_wrr1 == MODE_WRR) && gnt_valid) begin
            if (stay) begin
                cnt_next = cnt_eff + 1'b1;
            end else begin
                ptr_next = pick_idx;
                cnt_next = weight_width'(1);
            end
        end
    end

    always_comb begin
        rd_gnt = '0;
        if (rst && gnt_valid) begin
            rd_gnt[gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_reg       <= '0;
            cnt_reg       <= '0;
            mode_prev_reg <= MODE_SP;
        end else begin
            ptr_reg       <= ptr_next;
            cnt_reg       <= cnt_next;
            mode_prev_reg <= sp0_wrr1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sram_rd_en_reg   <= 1'b0;
            sram_rd_addr_reg <= '0;
            issue_port_reg   <= '0;
        end else begin
            sram_rd_en_reg <= gnt_valid;
            issue_port_reg <= gnt_idx;
            if (gnt_valid) begin
                sram_rd_addr_reg <= addr_arr[gnt_idx];
            end
        end
    end

    // Stage k is visible k+1 cycles after issue; the last stage lines up with sram_rd_data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < sram_latency; k++) begin
                tag_valid_reg[k] <= 1'b0;
                tag_port_reg[k]  <= '0;
            end
        end else begin
            tag_valid_reg[0] <= sram_rd_en_reg;
            tag_port_reg[0]  <= issue_port_reg;
            for (int k = 1; k < sram_latency; k++) begin
                tag_valid_reg[k] <= tag_valid_reg[k-1];
                tag_port_reg[k]  <= tag_port_reg[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out_reg       <= '0;
            data_out_valid_reg <= '0;
        end else if (tag_valid_reg[LAST]) begin
            data_out_reg       <= sram_rd_data;
            data_out_valid_reg <= num_of_ports'(1) << tag_port_reg[LAST];
        end else begin
            data_out_valid_reg <= '0;
        end
    end

    assign sram_rd_en     = sram_rd_en_reg;
    assign sram_rd_addr   = sram_rd_addr_reg;
    assign data_out       = data_out_reg;
    assign data_out_valid = data_out_valid_reg;

endmodule

// File: tb/tb_read_arbiter.sv
// Bench for read_arbiter: a cycle-level arbitration/return model checks every
// cycle, and directed scenarios pin grant sequences and latencies to literals.
`timescale 1ns/1ps
module tb_read_arbiter;

    localparam int N   = 16;
    localparam int DW  = 256;
    localparam int AW  = 14;
    localparam int WW  = 4;
    localparam int LAT = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            sp0_wrr1 = 1'b0;
    logic [N-1:0]    rd_req_p, rd_gnt, data_out_valid;
    logic [N*AW-1:0] rd_addr_p = '0;
    logic [N*WW-1:0] wrr_weight_p = '0;
    logic            sram_rd_en;
    logic [AW-1:0]   sram_rd_addr;
    logic [DW-1:0]   sram_rd_data, data_out;
    logic [N-1:0]    req_hold = '0;
    logic [N-1:0]    req_once = '0;

    assign rd_req_p = req_hold | req_once;

    always #5 clk = ~clk;

    read_arbiter #(
        .num_of_ports       (N),
        .arbiter_data_width (DW),
        .addr_width         (AW),
        .sram_latency       (LAT),
        .weight_width       (WW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .sp0_wrr1       (sp0_wrr1),
        .rd_req_p       (rd_req_p),
        .rd_addr_p      (rd_addr_p),
        .wrr_weight_p   (wrr_weight_p),
        .rd_gnt         (rd_gnt),
        .sram_rd_en     (sram_rd_en),
        .sram_rd_addr   (sram_rd_addr),
        .sram_rd_data   (sram_rd_data),
        .data_out       (data_out),
        .data_out_valid (data_out_valid)
    );

    function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
        return {8{{18'h2A5A5, a}}};
    endfunction

    // SRAM: word for the address presented LAT cycles earlier.
    logic [AW-1:0] sram_pipe [LAT];
    always @(posedge clk) begin
        sram_pipe[0] <= sram_rd_addr;
        for (int k = 1; k < LAT; k++) sram_pipe[k] <= sram_pipe[k-1];
    end
    assign sram_rd_data = word(sram_pipe[LAT-1]);

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    typedef struct {
        int            due;
        int            port;
        logic [AW-1:0] addr;
    } ret_t;

    ret_t          exp_q[$];
    int            m_ptr = 0;
    int            m_cnt = 0;
    logic          m_prev = 1'b0;
    logic          e_en = 1'b0;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_data = '0;

    int            acc_port[$], acc_cyc[$], ret_port[$], ret_cyc[$], en_cyc[$];
    logic [DW-1:0] ret_data[$];

    // Per-cycle model: predicts the grant from the arbitration rules and the
    // registered outputs from the accepts seen so far.
    always @(negedge clk) begin
        int g, c, w, j;
        logic [N-1:0] eg, ev;
        cyc++;
        if (!rst) begin
            chk("rst_gnt", rd_gnt, '0);
            chk("rst_en", sram_rd_en, '0);
            chk("rst_addr", sram_rd_addr, '0);
            chk("rst_valid", data_out_valid, '0);
            chk("rst_data", data_out, '0);
            m_ptr = 0; m_cnt = 0; m_prev = 1'b0;
            e_en = 1'b0; e_addr = '0; e_data = '0;
            exp_q.delete();
        end else begin
            chk("sram_rd_en", sram_rd_en, e_en);
            chk("sram_rd_addr", sram_rd_addr, e_addr);
            if (sram_rd_en) en_cyc.push_back(cyc);
            ev = '0;
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                ev[exp_q[0].port] = 1'b1;
                e_data = word(exp_q[0].addr);
                void'(exp_q.pop_front());
            end
            chk("data_out_valid", data_out_valid, ev);
            chk("data_out", data_out, e_data);
            if (data_out_valid != '0) begin
                ret_port.push_back(int'(data_out_valid));
                ret_cyc.push_back(cyc);
                ret_data.push_back(data_out);
            end

            c = (sp0_wrr1 != m_prev) ? 0 : m_cnt;
            g = -1;
            if (!sp0_wrr1) begin
                for (int k = 0; k < N; k++) if (g < 0 && rd_req_p[k]) g = k;
            end else begin
                w = int'(wrr_weight_p[m_ptr*WW +: WW]);
                if (w == 0) w = 1;
                if (rd_req_p[m_ptr] && c < w) begin
                    g = m_ptr;
                    c = c + 1;
                end else begin
                    for (int k = 1; k <= N; k++) begin
                        j = (m_ptr + k) % N;
                        if (g < 0 && rd_req_p[j]) g = j;
                    end
                    if (g >= 0) begin
                        m_ptr = g;
                        c = 1;
                    end
                end
            end
            m_cnt  = c;
            m_prev = sp0_wrr1;

            eg = '0;
            if (g >= 0) eg[g] = 1'b1;
            chk("rd_gnt", rd_gnt, eg);
            if (g >= 0) begin
                acc_port.push_back(g);
                acc_cyc.push_back(cyc);
                e_en   = 1'b1;
                e_addr = rd_addr_p[g*AW +: AW];
                exp_q.push_back('{cyc + LAT + 2, g, e_addr});
            end else begin
                e_en = 1'b0;
            end
        end
    end

    task automatic step();
        logic [N-1:0] g;
        @(negedge clk);
        g = rd_gnt;
        @(posedge clk);
        #1;
        req_once = req_once & ~g;
    endtask

    task automatic clear_logs();
        acc_port.delete(); acc_cyc.delete(); en_cyc.delete();
        ret_port.delete(); ret_cyc.delete(); ret_data.delete();
    endtask

    task automatic do_reset(input logic mode);
        rst = 1'b0;
        sp0_wrr1 = mode;
        req_hold = '0;
        req_once = '0;
        wrr_weight_p = '0;
        step();
        step();
        rst = 1'b1;
        clear_logs();
    endtask

    task automatic set_addr(input int p, input logic [AW-1:0] a);
        rd_addr_p[p*AW +: AW] = a;
    endtask

    task automatic set_w(input int p, input logic [WW-1:0] w);
        wrr_weight_p[p*WW +: WW] = w;
    endtask

    task automatic chk_seq(input string name, input int q[$], input int e[$]);
        chk({name, "_len"}, q.size(), e.size());
        for (int i = 0; i < e.size() && i < q.size(); i++) chk(name, q[i], e[i]);
    endtask

    initial begin
        int nv;
        int e[$];

        // Reset in flight
        do_reset(1'b0);
        set_addr(3, 14'h0010);
        req_once = 16'h0008;
        step();
        step();
        rst = 1'b0;
        #1;
        chk("t1_gnt", rd_gnt, '0);
        chk("t1_en", sram_rd_en, '0);
        chk("t1_addr", sram_rd_addr, '0);
        chk("t1_valid", data_out_valid, '0);
        chk("t1_data", data_out, '0);
        step();
        rst = 1'b1;
        nv = 0;
        repeat (10) begin
            step();
            if (data_out_valid != '0) nv++;
        end
        chk("t1_no_valid", nv, 0);

        // SP priority
        do_reset(1'b0);
        set_addr(1, 14'h0100);
        set_addr(4, 14'h0400);
        req_hold = 16'h0012;
        repeat (3) step();
        req_hold = 16'h0010;
        repeat (2) step();
        req_hold = '0;
        repeat (8) step();
        e = '{1, 1, 1, 4, 4};
        chk_seq("t2_grants", acc_port, e);
        chk("t2_ret_port", (ret_port.size() > 0) ? ret_port[0] : -1, 32'h0002);
        chk("t2_latency", (ret_cyc.size() > 0 && acc_cyc.size() > 0) ? ret_cyc[0] - acc_cyc[0] : -1, 4);
        chk("t2_data", (ret_data.size() > 0) ? ret_data[0] : '0, word(14'h0100));

        // WRR weights 3,1,0
        do_reset(1'b1);
        set_w(0, 4'd3);
        set_w(1, 4'd1);
        set_w(2, 4'd0);
        req_hold = 16'h0007;
        repeat (10) step();
        req_hold = '0;
        repeat (6) step();
        e = '{0, 0, 0, 1, 2, 0, 0, 0, 1, 2};
        chk_seq("t3_grants", acc_port, e);

        // WRR lone requester with wrap back to itself
        do_reset(1'b1);
        set_w(5, 4'd2);
        req_hold = 16'h0020;
        repeat (6) step();
        req_hold = '0;
        repeat (6) step();
        e = '{5, 5, 5, 5, 5, 5};
        chk_seq("t4_grants", acc_port, e);

        // Back-to-back ordering
        do_reset(1'b0);
        for (int k = 0; k < 4; k++) set_addr(k, AW'(14'h0200 + k));
        req_once = 16'h000F;
        repeat (12) step();
        e = '{0, 1, 2, 3};
        chk_seq("t5_grants", acc_port, e);
        chk("t5_en_count", en_cyc.size(), 4);
        chk("t5_en_span", (en_cyc.size() == 4) ? en_cyc[3] - en_cyc[0] : -1, 3);
        e = '{1, 2, 4, 8};
        chk_seq("t5_ret_ports", ret_port, e);
        for (int i = 0; i < 4 && i < ret_cyc.size() && i < ret_data.size(); i++) begin
            chk("t5_ret_cycle", ret_cyc[i] - acc_cyc[0], 4 + i);
            chk("t5_ret_data", ret_data[i], word(AW'(14'h0200 + i)));
        end

        // Mode switch clears WRR credit
        do_reset(1'b1);
        set_w(0, 4'd4);
        set_w(1, 4'd1);
        req_hold = 16'h0003;
        repeat (2) step();
        sp0_wrr1 = 1'b0;
        repeat (2) step();
        sp0_wrr1 = 1'b1;
        repeat (5) step();
        req_hold = '0;
        repeat (6) step();
        e = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
        chk_seq("t6_grants", acc_port, e);
        chk("t6_returns", ret_port.size(), 9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
